// File: rtl/multi_mac_col.sv
// Pixel x kernel-column MAC engine: one pixel times NO_COL_KERNEL weights per beat,
// accumulated over NO_CH channel beats, emitted as a tagged partial-sum column.
module multi_mac_col #(
  parameter int BIT_WIDTH     = 8,
  parameter int NO_COL_KERNEL = 5,
  parameter int NO_CH         = 4,
  parameter int SIGNED        = 0,
  localparam int ACC_W = 2 * BIT_WIDTH + $clog2(NO_CH),
  localparam int CNT_W = (NO_COL_KERNEL > 1) ? $clog2(NO_COL_KERNEL) : 1,
  localparam int CH_W  = $clog2(NO_CH) + 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_clear,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [BIT_WIDTH*NO_COL_KERNEL-1:0] i_weight_col,
  input  logic [BIT_WIDTH-1:0]             i_pix,
  output logic                             o_valid,
  input  logic                             i_out_ready,
  output logic [ACC_W*NO_COL_KERNEL-1:0]   o_col,
  output logic [CNT_W-1:0]                 o_kercol_cnt,
  output logic                             o_last_col,
  output logic [CH_W-1:0]                  o_ch_cnt
);

  localparam int PROD_W = 2 * BIT_WIDTH;

  // Operands are widened to the product width first so one multiply serves both modes.
  function automatic logic signed [PROD_W-1:0] mul_lane(input logic [BIT_WIDTH-1:0] a,
                                                        input logic [BIT_WIDTH-1:0] b);
    logic signed [PROD_W-1:0] sa;
    logic signed [PROD_W-1:0] sb;
    if (SIGNED != 0) begin
      sa = {{BIT_WIDTH{a[BIT_WIDTH-1]}}, a};
      sb = {{BIT_WIDTH{b[BIT_WIDTH-1]}}, b};
    end else begin
      sa = {{BIT_WIDTH{1'b0}}, a};
      sb = {{BIT_WIDTH{1'b0}}, b};
    end
    mul_lane = sa * sb;
  endfunction

  function automatic logic signed [ACC_W-1:0] ext_prod(input logic signed [PROD_W-1:0] p);
    logic signed [ACC_W-1:0] r;
    if (SIGNED != 0) r = ACC_W'(p);
    else             r = ACC_W'($unsigned(p));
    ext_prod = r;
  endfunction

  logic                     en;
  logic                     vld_p1;
  logic signed [PROD_W-1:0] prod_p1 [NO_COL_KERNEL];
  logic signed [ACC_W-1:0]  acc_p2  [NO_COL_KERNEL];
  logic [CH_W-1:0]          ch_p2;
  logic                     ch_last_p2;
  logic [ACC_W*NO_COL_KERNEL-1:0] sum_p2;

  assign en         = !o_valid || i_out_ready;
  assign o_ready    = en;
  assign ch_last_p2 = (ch_p2 == CH_W'(NO_CH - 1));
  assign o_ch_cnt   = ch_p2;
  assign o_last_col = (o_kercol_cnt == CNT_W'(NO_COL_KERNEL - 1));

  // Stage 1: lane products
  always_ff @(posedge i_clk) begin
    if (en) begin
      for (int k = 0; k < NO_COL_KERNEL; k++)
        prod_p1[k] <= mul_lane(i_pix, i_weight_col[k*BIT_WIDTH +: BIT_WIDTH]);
    end
  end

  // Stage 2: channel accumulation; the first beat of a column restarts from zero
  always_comb begin
    sum_p2 = '0;
    for (int k = 0; k < NO_COL_KERNEL; k++)
      sum_p2[k*ACC_W +: ACC_W] = ((ch_p2 == '0) ? '0 : acc_p2[k]) + ext_prod(prod_p1[k]);
  end

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      for (int k = 0; k < NO_COL_KERNEL; k++)
        acc_p2[k] <= '0;
    end else if (en && vld_p1) begin
      for (int k = 0; k < NO_COL_KERNEL; k++)
        acc_p2[k] <= sum_p2[k*ACC_W +: ACC_W];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1       <= 1'b0;
      ch_p2        <= '0;
      o_valid      <= 1'b0;
      o_col        <= '0;
      o_kercol_cnt <= '0;
    end else if (i_clear) begin
      vld_p1       <= 1'b0;
      ch_p2        <= '0;
      o_valid      <= 1'b0;
      o_kercol_cnt <= '0;
    end else begin
      if (en) begin
        vld_p1 <= i_valid;
        if (vld_p1 && ch_last_p2) begin
          ch_p2   <= '0;
          o_valid <= 1'b1;
          o_col   <= sum_p2;
        end else begin
          o_valid <= 1'b0;
          if (vld_p1)
            ch_p2 <= ch_p2 + 1'b1;
        end
      end
      // Kernel-column tag advances once per column handed downstream
      if (o_valid && i_out_ready)
        o_kercol_cnt <= (o_kercol_cnt == CNT_W'(NO_COL_KERNEL - 1)) ? '0 : o_kercol_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_multi_mac_col.sv
// Bench for multi_mac_col: an unsigned and a signed instance share stimulus and are
// checked against a channel-sum reference model through output scoreboards.
module tb_multi_mac_col;
  localparam int BW    = 8;
  localparam int NK    = 5;
  localparam int NCH   = 4;
  localparam int ACC_W = 2 * BW + $clog2(NCH);
  localparam int CW    = ACC_W * NK;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clr = 1'b0;
  logic          vin = 1'b0;
  logic          out_rdy = 1'b1;
  logic [BW*NK-1:0] wcol = '0;
  logic [BW-1:0] pix = '0;
  logic          ordy_u, ordy_s, ovld_u, ovld_s, last_u, last_s;
  logic [CW-1:0] col_u, col_s;
  logic [2:0]    kc_u, kc_s;
  logic [2:0]    ch_u, ch_s;

  int errors = 0;
  int checks = 0;
  bit bp_mode = 1'b0;

  always #5 clk = ~clk;

  multi_mac_col #(.BIT_WIDTH(BW), .NO_COL_KERNEL(NK), .NO_CH(NCH), .SIGNED(0)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr), .i_valid(vin), .o_ready(ordy_u),
    .i_weight_col(wcol), .i_pix(pix), .o_valid(ovld_u), .i_out_ready(out_rdy),
    .o_col(col_u), .o_kercol_cnt(kc_u), .o_last_col(last_u), .o_ch_cnt(ch_u));

  multi_mac_col #(.BIT_WIDTH(BW), .NO_COL_KERNEL(NK), .NO_CH(NCH), .SIGNED(1)) u_sdut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr), .i_valid(vin), .o_ready(ordy_s),
    .i_weight_col(wcol), .i_pix(pix), .o_valid(ovld_s), .i_out_ready(out_rdy),
    .o_col(col_s), .o_kercol_cnt(kc_s), .o_last_col(last_s), .o_ch_cnt(ch_s));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic longint ulane(input logic [CW-1:0] v, input int k);
    logic [ACC_W-1:0] t;
    t = v[k*ACC_W +: ACC_W];
    return longint'(t);
  endfunction

  function automatic longint slane(input logic [CW-1:0] v, input int k);
    logic signed [ACC_W-1:0] t;
    t = v[k*ACC_W +: ACC_W];
    return longint'(t);
  endfunction

  // Reference model: per-lane channel sums of pixel*weight, column pushed on its NO_CH-th beat
  longint        su [NK];
  longint        ss [NK];
  int            beat_cnt = 0;
  logic [CW-1:0] qu [$];
  logic [CW-1:0] qs [$];
  int            exp_kc_u = 0;
  int            exp_kc_s = 0;
  int            cols_u = 0;
  int            kc_log [$];
  int            last_log [$];

  task automatic model_flush();
    for (int k = 0; k < NK; k++) begin
      su[k] = 0;
      ss[k] = 0;
    end
    beat_cnt = 0;
    qu.delete();
    qs.delete();
    exp_kc_u = 0;
    exp_kc_s = 0;
  endtask

  initial begin
    logic [CW-1:0] eu, es;
    byte sp, sw;
    logic [BW-1:0] w;
    model_flush();
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        model_flush();
        continue;
      end
      if (ovld_u && out_rdy) begin
        if (qu.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_col_u: got col %h expected none", col_u);
        end else begin
          eu = qu.pop_front();
          chk_vec("col_u", col_u, eu);
          chk("kercol_u", kc_u, exp_kc_u);
          chk("last_u", last_u, exp_kc_u == NK - 1);
          kc_log.push_back(int'(kc_u));
          last_log.push_back(int'(last_u));
          exp_kc_u = (exp_kc_u + 1) % NK;
          cols_u++;
        end
      end
      if (ovld_s && out_rdy) begin
        if (qs.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_col_s: got col %h expected none", col_s);
        end else begin
          es = qs.pop_front();
          chk_vec("col_s", col_s, es);
          chk("kercol_s", kc_s, exp_kc_s);
          exp_kc_s = (exp_kc_s + 1) % NK;
        end
      end
      chk("o_ready_u", ordy_u, !ovld_u || out_rdy);
      chk("o_ready_s", ordy_s, !ovld_s || out_rdy);
      if (clr) begin
        model_flush();
      end else if (vin && ordy_u) begin
        for (int k = 0; k < NK; k++) begin
          w = wcol[k*BW +: BW];
          sp = pix;
          sw = w;
          su[k] += longint'(pix) * longint'(w);
          ss[k] += longint'(sp) * longint'(sw);
        end
        beat_cnt++;
        if (beat_cnt == NCH) begin
          for (int k = 0; k < NK; k++) begin
            eu[k*ACC_W +: ACC_W] = su[k][ACC_W-1:0];
            es[k*ACC_W +: ACC_W] = ss[k][ACC_W-1:0];
            su[k] = 0;
            ss[k] = 0;
          end
          qu.push_back(eu);
          qs.push_back(es);
          beat_cnt = 0;
        end
      end
    end
  end

  // Random downstream backpressure when enabled
  initial begin
    forever begin
      @(negedge clk);
      if (bp_mode) out_rdy = ($urandom_range(0, 9) < 7);
    end
  end

  // Present one beat and hold it until the DUT takes it; returns on the next negedge
  task automatic send(input logic [BW-1:0] p, input logic [BW*NK-1:0] w);
    bit ok;
    ok = 1'b0;
    vin  = 1'b1;
    pix  = p;
    wcol = w;
    for (int t = 0; t < 200; t++) begin
      #4;
      ok = ordy_u;
      @(negedge clk);
      if (ok) break;
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
    end
    vin = 1'b0;
  endtask

  task automatic send_rand();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    send(BW'($urandom_range(0, 255)), r[BW*NK-1:0]);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      if (qu.size() == 0 && qs.size() == 0 && !ovld_u && !ovld_s) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("drain", done, 1);
  endtask

  initial begin
    logic [BW*NK-1:0] w2;
    int cols_before;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_o_valid", ovld_u, 0);
    chk("rst_o_col", ulane(col_u, 0) + ulane(col_u, 4), 0);
    chk("rst_kercol", kc_u, 0);
    chk("rst_last", last_u, 0);
    chk("rst_ch_cnt", ch_u, 0);
    chk("rst_o_valid_s", ovld_s, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: pix=3, weights 2, four beats, two-cycle latency
    for (int i = 0; i < NCH; i++) send(8'd3, {NK{8'd2}});
    chk("t1_valid_early", ovld_u, 0);
    chk("t1_ch_cnt", ch_u, 3);
    @(negedge clk);
    chk("t1_valid", ovld_u, 1);
    for (int k = 0; k < NK; k++) chk("t1_lane", ulane(col_u, k), 24);
    chk("t1_kercol", kc_u, 0);
    chk("t1_ch_cnt_wrap", ch_u, 0);

    // T2: signed extremes
    w2 = '0;
    w2[7:0]  = 8'h80;
    w2[15:8] = 8'h7F;
    for (int i = 0; i < NCH; i++) send(8'h80, w2);
    @(negedge clk);
    chk("t2_valid_s", ovld_s, 1);
    chk("t2_lane0_s", slane(col_s, 0), 65536);
    chk("t2_lane1_s", slane(col_s, 1), -65024);
    chk("t2_lane0_u", ulane(col_u, 0), 65536);
    chk("t2_lane1_u", ulane(col_u, 1), 65024);
    drain();

    // Async reset mid-column discards the partial sums
    send_rand();
    send_rand();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_o_valid", ovld_u, 0);
    chk("rstmid_ch_cnt", ch_u, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T3: six columns from a fresh start, tag sequence 0..4,0
    kc_log.delete();
    last_log.delete();
    for (int c = 0; c < 6; c++)
      for (int b = 0; b < NCH; b++) send_rand();
    drain();
    chk("t3_count", kc_log.size(), 6);
    if (kc_log.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("t3_kercol", kc_log[i], i % NK);
        chk("t3_last", last_log[i], (i == NK - 1) ? 1 : 0);
      end
    end

    // T4: downstream stall with a column presented
    out_rdy = 1'b0;
    for (int b = 0; b < NCH; b++) send_rand();
    fork
      begin
        for (int b = 0; b < NCH; b++) send_rand();
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
          if (ovld_u) begin
            seen = 1'b1;
            break;
          end
          @(negedge clk);
        end
        chk("t4_valid_seen", seen, 1);
        for (int i = 0; i < 5; i++) begin
          chk("t4_o_ready_stalled", ordy_u, 0);
          chk("t4_valid_held", ovld_u, 1);
          if (qu.size() > 0) chk_vec("t4_col_held", col_u, qu[0]);
          @(negedge clk);
        end
        out_rdy = 1'b1;
      end
    join
    drain();

    // T5: clear after two beats, beat presented with clear is dropped
    send_rand();
    send_rand();
    clr  = 1'b1;
    vin  = 1'b1;
    pix  = 8'd1;
    wcol = {NK{8'd1}};
    @(negedge clk);
    clr = 1'b0;
    vin = 1'b0;
    chk("t5_kercol_cleared", kc_u, 0);
    chk("t5_ch_cleared", ch_u, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_valid", ovld_u, 0);
      @(negedge clk);
    end
    for (int b = 0; b < NCH; b++) send(8'd1, {NK{8'd1}});
    @(negedge clk);
    chk("t5_valid", ovld_u, 1);
    for (int k = 0; k < NK; k++) chk("t5_lane", ulane(col_u, k), 4);
    chk("t5_kercol", kc_u, 0);
    drain();

    // T6: random gaps and backpressure over 1000 columns
    cols_before = cols_u;
    bp_mode = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      for (int b = 0; b < NCH; b++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        send_rand();
      end
    end
    bp_mode = 1'b0;
    @(negedge clk);
    out_rdy = 1'b1;
    drain();
    chk("t6_columns", cols_u - cols_before, 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
